// File: rtl/matriz_divisao_escalar.sv
// Divides each signed element of a packed 5x5 matrix by a signed scalar using one shared restoring divider.
// Optional build macro MATRIZ_DIV_SATURATE_EN: an overflowing element is written as +max instead of the wrapped value.
module matriz_divisao_escalar #(
   parameter int unsigned N = 25,
   parameter int unsigned W = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [W-1:0]   data_escalar,
   input  logic [N*W-1:0] matriz_a,
   output logic [N*W-1:0] matriz_resultante,
   output logic           busy,
   output logic           done,
   output logic           overflow,
   output logic           div_zero
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ZERO  = 3'd1,
      LOAD  = 3'd2,
      ITER  = 3'd3,
      STORE = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t state_q, state_d;

   logic [N*W-1:0] a_q;
   logic [W-1:0]   d_q;
   logic [IW-1:0]  idx_q;
   logic [CW-1:0]  cnt_q;
   logic [W-1:0]   dvd_q;
   logic [W:0]     dsr_q;
   logic [W:0]     rem_q;
   logic [W-1:0]   quo_q;
   logic           neg_q;

   logic [W-1:0]   elem;
   logic [W:0]     rem_shift;
   logic [W:0]     rem_sub;
   logic           sub_ok;
   logic           store_ovf;
   logic [W-1:0]   store_val;

   // Magnitude as W-bit unsigned; the most negative value maps to 2^(W-1) without loss.
   function automatic logic [W-1:0] umag(input logic [W-1:0] v);
      umag = v[W-1] ? (~v + W'(1)) : v;
   endfunction

   assign elem = a_q[int'(idx_q)*W +: W];

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (data_escalar == '0) ? ZERO : LOAD;
         ZERO:    state_d = DONE;
         LOAD:    state_d = ITER;
         ITER:    if (cnt_q == CW'(W-1)) state_d = STORE;
         STORE:   state_d = (idx_q == IW'(N-1)) ? DONE : LOAD;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // One restoring step: shift in the next dividend bit, subtract the divisor if it fits
   always_comb begin
      rem_shift = {rem_q[W-1:0], dvd_q[W-1]};
      rem_sub   = rem_shift - dsr_q;
      sub_ok    = (rem_shift >= dsr_q);
   end

   // Signed quotient for the current element, with overflow handling
   always_comb begin
      store_ovf = ~neg_q & quo_q[W-1];
      store_val = neg_q ? (~quo_q + W'(1)) : quo_q;
      if (store_ovf) begin
`ifdef MATRIZ_DIV_SATURATE_EN
         store_val = {1'b0, {(W-1){1'b1}}};
`else
         store_val = quo_q;
`endif
      end
   end

   // Operand capture and divider datapath
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q   <= '0;
         d_q   <= '0;
         idx_q <= '0;
         cnt_q <= '0;
         dvd_q <= '0;
         dsr_q <= '0;
         rem_q <= '0;
         quo_q <= '0;
         neg_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q   <= matriz_a;
                  d_q   <= data_escalar;
                  idx_q <= '0;
               end
            end
            LOAD: begin
               dvd_q <= umag(elem);
               dsr_q <= {1'b0, umag(d_q)};
               neg_q <= elem[W-1] ^ d_q[W-1];
               rem_q <= '0;
               quo_q <= '0;
               cnt_q <= '0;
            end
            ITER: begin
               dvd_q <= {dvd_q[W-2:0], 1'b0};
               rem_q <= sub_ok ? rem_sub : rem_shift;
               quo_q <= {quo_q[W-2:0], sub_ok};
               cnt_q <= cnt_q + CW'(1);
            end
            STORE: begin
               if (idx_q != IW'(N-1)) idx_q <= idx_q + IW'(1);
            end
            default: ;
         endcase
      end
   end

   // Registered outputs; done rises the cycle after the DONE state, as busy falls
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         matriz_resultante <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
         overflow          <= 1'b0;
         div_zero          <= 1'b0;
      end else begin
         done <= (state_q == DONE);
         case (state_q)
            IDLE: begin
               if (start) begin
                  busy     <= 1'b1;
                  overflow <= 1'b0;
                  div_zero <= 1'b0;
               end
            end
            ZERO: begin
               matriz_resultante <= '0;
               div_zero          <= 1'b1;
            end
            STORE: begin
               matriz_resultante[int'(idx_q)*W +: W] <= store_val;
               if (store_ovf) overflow <= 1'b1;
            end
            DONE: busy <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_matriz_divisao_escalar.sv
// Directed testbench for matriz_divisao_escalar with hand-computed quotients.
module tb_matriz_divisao_escalar;

   localparam int unsigned N  = 25;
   localparam int unsigned W  = 8;
   localparam int unsigned MW = N * W;

   logic          clk;
   logic          reset;
   logic          start;
   logic [W-1:0]  data_escalar;
   logic [MW-1:0] matriz_a;
   logic [MW-1:0] matriz_resultante;
   logic          busy;
   logic          done;
   logic          overflow;
   logic          div_zero;

   int n_checks = 0;
   int n_errors = 0;

   matriz_divisao_escalar #(.N(N), .W(W)) dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .data_escalar      (data_escalar),
      .matriz_a          (matriz_a),
      .matriz_resultante (matriz_resultante),
      .busy              (busy),
      .done              (done),
      .overflow          (overflow),
      .div_zero          (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [MW-1:0] fill(input logic [W-1:0] v);
      logic [MW-1:0] m;
      for (int i = 0; i < N; i++) m[i*W +: W] = v;
      return m;
   endfunction

   // Issue one operation; optionally inject a second start or a reset mid-flight.
   task automatic run_op(input logic [MW-1:0] a, input logic [W-1:0] d,
                         input int inject_at, input int reset_at, output int lat);
      bit found;
      bit busy_low;
      lat      = -1;
      found    = 1'b0;
      busy_low = 1'b0;
      @(negedge clk);
      matriz_a     = a;
      data_escalar = d;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int c = 1; c <= 300 && !found; c++) begin
         @(posedge clk);
         #1;
         if (c == inject_at) begin
            matriz_a     = fill(8'h55);
            data_escalar = 8'h00;
            start        = 1'b1;
         end
         if (c == inject_at + 1) start = 1'b0;
         if (c == reset_at) begin
            reset = 1'b1;
            #1;
            check("reset_mid_outputs", MW'({matriz_resultante, busy, done, overflow, div_zero}), '0);
            @(negedge clk);
            @(negedge clk);
            reset = 1'b0;
         end
         if (done) begin
            found = 1'b1;
            lat   = c;
            check("busy_at_done", MW'(busy), MW'(0));
            @(posedge clk);
            #1;
            check("done_one_cycle", MW'(done), MW'(0));
         end else if (!busy && reset_at < 0) begin
            busy_low = 1'b1;
         end
      end
      if (reset_at < 0) check("busy_held", MW'(busy_low), MW'(0));
   endtask

   logic [MW-1:0] a, exp_m;
   int lat;

   initial begin
      reset        = 1'b1;
      start        = 1'b0;
      data_escalar = '0;
      matriz_a     = '0;
      #12;
      check("reset_result", matriz_resultante, '0);
      check("reset_flags", MW'({busy, done, overflow, div_zero}), MW'(0));
      @(negedge clk);
      reset = 1'b0;

      // 100 / 7 = 14
      run_op(fill(8'd100), 8'd7, -1, -1, lat);
      check("lat_100_7", MW'(lat), MW'(251));
      check("res_100_7", matriz_resultante, fill(8'h0E));
      check("flags_100_7", MW'({overflow, div_zero}), MW'(0));

      // -7 / 2 = -3 and 7 / 2 = 3, truncation toward zero
      for (int i = 0; i < N; i++) begin
         a[i*W +: W]     = (i % 2 == 0) ? 8'hF9 : 8'h07;
         exp_m[i*W +: W] = (i % 2 == 0) ? 8'hFD : 8'h03;
      end
      run_op(a, 8'd2, -1, -1, lat);
      check("lat_alt", MW'(lat), MW'(251));
      check("res_alt", matriz_resultante, exp_m);

      // -128 / -2 = 64, 127 / -2 = -63, 0 / -2 = 0
      a = '0; a[0 +: W] = 8'h80; a[24*W +: W] = 8'h7F;
      exp_m = '0; exp_m[0 +: W] = 8'h40; exp_m[24*W +: W] = 8'hC1;
      run_op(a, 8'hFE, -1, -1, lat);
      check("res_m128_m2", matriz_resultante, exp_m);
      check("flags_m128_m2", MW'({overflow, div_zero}), MW'(0));

      // divide by zero
      run_op(fill(8'd100), 8'd0, -1, -1, lat);
      check("lat_zero", MW'(lat), MW'(2));
      check("res_zero", matriz_resultante, '0);
      check("flags_zero", MW'({overflow, div_zero}), MW'(2'b01));

      // -128 / -1 overflows; 10 / -1 = -10
      a = fill(8'd10); a[5*W +: W] = 8'h80;
      exp_m = fill(8'hF6);
`ifdef MATRIZ_DIV_SATURATE_EN
      exp_m[5*W +: W] = 8'h7F;
`else
      exp_m[5*W +: W] = 8'h80;
`endif
      run_op(a, 8'hFF, -1, -1, lat);
      check("lat_ovf", MW'(lat), MW'(251));
      check("res_ovf", matriz_resultante, exp_m);
      check("flags_ovf", MW'({overflow, div_zero}), MW'(2'b10));

      // -100 / 3 = -33; -128 / 3 = -42; overflow must clear
      a = fill(8'h9C); a[0 +: W] = 8'h80;
      exp_m = fill(8'hDF); exp_m[0 +: W] = 8'hD6;
      run_op(a, 8'd3, -1, -1, lat);
      check("res_neg", matriz_resultante, exp_m);
      check("flags_neg", MW'({overflow, div_zero}), MW'(0));

      // -128 / 1 = -128, no overflow
      a = fill(8'h80);
      run_op(a, 8'd1, -1, -1, lat);
      check("res_m128_1", matriz_resultante, fill(8'h80));
      check("flags_m128_1", MW'({overflow, div_zero}), MW'(0));

      // second start at cycle 50 is ignored
      run_op(fill(8'd100), 8'd7, 50, -1, lat);
      check("lat_inject", MW'(lat), MW'(251));
      check("res_inject", matriz_resultante, fill(8'h0E));
      check("flags_inject", MW'({overflow, div_zero}), MW'(0));

      // reset at cycle 100: no done afterwards
      run_op(fill(8'd50), 8'd5, -1, 100, lat);
      check("no_done_after_reset", MW'(lat), MW'(-1));

      // recovery: 50 / -5 = -10
      run_op(fill(8'd50), 8'hFB, -1, -1, lat);
      check("lat_recover", MW'(lat), MW'(251));
      check("res_recover", matriz_resultante, fill(8'hF6));

      // results hold while idle
      repeat (5) @(posedge clk);
      #1;
      check("res_hold", matriz_resultante, fill(8'hF6));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
